dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer placed directly upstream of the SRAM-table DDS core. It drives that core's 32-bit frequency control word and 32-bit phase offset. It steps fcw linearly from a start to a stop value, holding each value for a programmable dwell time, with an optional return leg (triangle). It gates stepping on the core's table-loaded/running indication (dds_ready, driven from the core's writed_ output), so no step is consumed while the core is loading or held in reset.

---
 rtl/dds_sweep_ctrl_if.sv | 42 ++++
 rtl/dds_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep controller bus: sweep configuration and DDS readiness in, fcw/offset/status out.
// The loop input exists only when DDS_SWEEP_LOOP_EN is defined.
interface dds_sweep_ctrl_if #(
    parameter int FCW_W   = 32,
    parameter int DWELL_W = 16
);
    logic               dds_ready;
    logic               start;
    logic               abort;
    logic [FCW_W-1:0]   start_fcw;
    logic [FCW_W-1:0]   stop_fcw;
    logic [FCW_W-1:0]   step_fcw;
    logic [DWELL_W-1:0] dwell;
    logic [31:0]        phase_offset;
    logic               triangle;
`ifdef DDS_SWEEP_LOOP_EN
    logic               loop;
`endif
    logic [FCW_W-1:0]   fcw;
    logic [31:0]        offset;
    logic               busy;
    logic               done;
    logic               step_strobe;

    modport master (
`ifdef DDS_SWEEP_LOOP_EN
        output loop,
`endif
        output dds_ready, start, abort, start_fcw, stop_fcw, step_fcw, dwell,
        output phase_offset, triangle,
        input  fcw, offset, busy, done, step_strobe
    );

    modport slave (
`ifdef DDS_SWEEP_LOOP_EN
        input  loop,
`endif
        input  dds_ready, start, abort, start_fcw, stop_fcw, step_fcw, dwell,
        input  phase_offset, triangle,
        output fcw, offset, busy, done, step_strobe
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear fcw sweep sequencer (optional triangle return leg) gated by DDS readiness; all outputs registered.
// Optional DDS_SWEEP_LOOP_EN adds a loop input that restarts the sweep at completion instead of idling.
module dds_sweep_ctrl #(
    parameter int FCW_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic            sys_clk,
    input  logic            reset,
    dds_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RDY = 2'd1, DWELL = 2'd2} state_t;

    typedef struct packed {
        logic [FCW_W-1:0]   start_fcw;
        logic [FCW_W-1:0]   stop_fcw;
        logic [FCW_W-1:0]   step_fcw;
        logic [DWELL_W-1:0] reload;
        logic               triangle;
        logic               loop;
    } cfg_t;

    state_t             state, state_nxt;
    cfg_t               cfg, cfg_nxt;
    logic [FCW_W-1:0]   fcw_q, fcw_nxt, target, target_nxt;
    logic [31:0]        offset_q, offset_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               dir, dir_nxt, leg, leg_nxt;
    logic               done_q, done_nxt, strobe_q, strobe_nxt;
    logic               loop_in, can_step, can_turn;

`ifdef DDS_SWEEP_LOOP_EN
    assign loop_in = bus.loop;
`else
    assign loop_in = 1'b0;
`endif

    // Saturating step toward tgt: never overshoots and never wraps.
    function automatic logic [FCW_W-1:0] next_toward(input logic [FCW_W-1:0] cur,
                                                     input logic [FCW_W-1:0] tgt,
                                                     input logic [FCW_W-1:0] step,
                                                     input logic up);
        logic [FCW_W:0]   sum;
        logic [FCW_W-1:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = cur - tgt;
        if (up)
            return (sum >= {1'b0, tgt}) ? tgt : sum[FCW_W-1:0];
        else
            return (diff <= step) ? tgt : cur - step;
    endfunction

    assign can_step = (fcw_q != target) && (cfg.step_fcw != '0);
    assign can_turn = cfg.triangle && !leg && (cfg.start_fcw != cfg.stop_fcw) && (cfg.step_fcw != '0);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= IDLE;
            cfg      <= '0;
            fcw_q    <= '0;
            offset_q <= '0;
            target   <= '0;
            dir      <= 1'b0;
            leg      <= 1'b0;
            cnt      <= '0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cfg      <= cfg_nxt;
            fcw_q    <= fcw_nxt;
            offset_q <= offset_nxt;
            target   <= target_nxt;
            dir      <= dir_nxt;
            leg      <= leg_nxt;
            cnt      <= cnt_nxt;
            done_q   <= done_nxt;
            strobe_q <= strobe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.start) state_nxt = WAIT_RDY;
            WAIT_RDY: begin
                if (bus.abort)          state_nxt = IDLE;
                else if (bus.dds_ready) state_nxt = DWELL;
            end
            DWELL: begin
                if (bus.abort)           state_nxt = IDLE;
                else if (!bus.dds_ready) state_nxt = WAIT_RDY;
                else if (cnt == '0 && !can_step && !can_turn && !cfg.loop)
                    state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_nxt    = cfg;
        fcw_nxt    = fcw_q;
        offset_nxt = offset_q;
        target_nxt = target;
        dir_nxt    = dir;
        leg_nxt    = leg;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        strobe_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    cfg_nxt.start_fcw = bus.start_fcw;
                    cfg_nxt.stop_fcw  = bus.stop_fcw;
                    cfg_nxt.step_fcw  = bus.step_fcw;
                    cfg_nxt.reload    = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
                    cfg_nxt.triangle  = bus.triangle;
                    cfg_nxt.loop      = loop_in;
                    fcw_nxt           = bus.start_fcw;
                    offset_nxt        = bus.phase_offset;
                    target_nxt        = bus.stop_fcw;
                    dir_nxt           = (bus.stop_fcw >= bus.start_fcw);
                    leg_nxt           = 1'b0;
                end
            end
            WAIT_RDY: begin
                if (!bus.abort && bus.dds_ready) cnt_nxt = cfg.reload;
            end
            DWELL: begin
                // abort and ready loss freeze fcw; the dwell reloads on re-entry
                if (!bus.abort && bus.dds_ready) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - DWELL_W'(1);
                    end else if (can_step) begin
                        fcw_nxt    = next_toward(fcw_q, target, cfg.step_fcw, dir);
                        strobe_nxt = 1'b1;
                        cnt_nxt    = cfg.reload;
                    end else if (can_turn) begin
                        target_nxt = cfg.start_fcw;
                        dir_nxt    = !dir;
                        leg_nxt    = 1'b1;
                        fcw_nxt    = next_toward(fcw_q, cfg.start_fcw, cfg.step_fcw, !dir);
                        strobe_nxt = 1'b1;
                        cnt_nxt    = cfg.reload;
                    end else begin
                        done_nxt = 1'b1;
                        if (cfg.loop) begin
                            fcw_nxt    = cfg.start_fcw;
                            target_nxt = cfg.stop_fcw;
                            dir_nxt    = (cfg.stop_fcw >= cfg.start_fcw);
                            leg_nxt    = 1'b0;
                            cnt_nxt    = cfg.reload;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.fcw         = fcw_q;
    assign bus.offset      = offset_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.step_strobe = strobe_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a list-based sweep model queues expected strobe/done events
// (value and spacing in cycles); a negedge monitor pops and compares whenever the DUT reports one.
module tb_dds_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.FCW_W(32), .DWELL_W(16)) bus ();
    dds_sweep_ctrl #(.FCW_W(32), .DWELL_W(16)) dut (.sys_clk(clk), .reset(rst), .bus(bus));

    typedef struct {
        bit              is_done;
        longint unsigned val;
        int              gap;
    } ev_t;

    ev_t exp_q[$];
    int  total   = 0;
    int  bad     = 0;
    int  cyc     = 0;
    int  ref_cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst && (bus.step_strobe || bus.done)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got strobe=%0b done=%0b fcw=0x%0h expected none",
                         bus.step_strobe, bus.done, bus.fcw);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind_done", 64'(bus.done), 64'(e.is_done));
                chk("event_fcw", 64'(bus.fcw), 64'(e.val));
                if (e.gap >= 0) chk("event_gap", 64'(cyc - ref_cyc), 64'(e.gap));
                chk("busy_at_event", 64'(bus.busy), 64'(!e.is_done));
            end
            ref_cyc = cyc;
        end
    end

    // Expected sweep as a list of values: walk to stop, optionally back to start, then done.
    function automatic longint unsigned model(input longint unsigned s, input longint unsigned t,
                                              input longint unsigned st, input int dw,
                                              input bit triang, input int first_gap);
        longint unsigned v = s;
        int d = (dw == 0) ? 1 : dw;
        int g = first_gap;
        ev_t e;
        if (st != 0) begin
            while (v != t) begin
                if (t > s) v = (v + st > t) ? t : v + st;
                else       v = (v >= t + st) ? v - st : t;
                e = '{1'b0, v, g}; exp_q.push_back(e); g = d;
            end
            if (triang && s != t) begin
                while (v != s) begin
                    if (s > t) v = (v + st > s) ? s : v + st;
                    else       v = (v >= s + st) ? v - st : s;
                    e = '{1'b0, v, g}; exp_q.push_back(e); g = d;
                end
            end
        end
        e = '{1'b1, v, g}; exp_q.push_back(e);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input logic [31:0] s, input logic [31:0] t, input logic [31:0] st,
                             input int dw, input bit triang, input logic [31:0] ph,
                             input bit gated, output longint unsigned last);
        int d = (dw == 0) ? 1 : dw;
        bus.start_fcw    = s;
        bus.stop_fcw     = t;
        bus.step_fcw     = st;
        bus.dwell        = 16'(dw);
        bus.triangle     = triang;
        bus.phase_offset = ph;
        bus.start        = 1'b1;
        ref_cyc          = cyc;
        last = model(s, t, st, dw, triang, gated ? d + 1 : d + 2);
        tick(1);
        bus.start = 1'b0;
        chk("accept_busy", 64'(bus.busy), 64'd1);
        chk("accept_fcw", 64'(bus.fcw), 64'(s));
        chk("accept_offset", 64'(bus.offset), 64'(ph));
    endtask

    task automatic wait_done(input string nm, input longint unsigned last);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
            tick(1);
            n++;
        end
        chk({nm, "_completed"}, 64'(n < 3000), 64'd1);
        tick(2);
        chk({nm, "_fcw_held"}, 64'(bus.fcw), 64'(last));
    endtask

    task automatic wait_q(input int sz);
        int n = 0;
        while (exp_q.size() > sz && n < 3000) begin
            tick(1);
            n++;
        end
        chk("queue_drain_in_time", 64'(n < 3000), 64'd1);
    endtask

    task automatic abort_after_first(input logic [31:0] s, input logic [31:0] t, input int dw);
        longint unsigned last;
        run_sweep(s, t, 32'd10, dw, 1'b0, 32'h1234, 1'b0, last);
        while (exp_q.size() > 1) exp_q.delete(exp_q.size() - 1);
        wait_q(0);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_fcw", 64'(bus.fcw), 64'(s + 32'd10));
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_strobe", 64'(bus.step_strobe), 64'd0);
        tick(8);
    endtask

    initial begin
        longint unsigned last;
        longint unsigned s, t, dd;
        logic [31:0] st;
        bus.dds_ready    = 1'b1;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.start_fcw    = '0;
        bus.stop_fcw     = '0;
        bus.step_fcw     = '0;
        bus.dwell        = '0;
        bus.phase_offset = '0;
        bus.triangle     = 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
        bus.loop         = 1'b0;
`endif
        tick(3);
        chk("reset_fcw", 64'(bus.fcw), 64'd0);
        chk("reset_offset", 64'(bus.offset), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_strobe", 64'(bus.step_strobe), 64'd0);
        rst = 1'b0;
        tick(2);

        run_sweep(32'd100, 32'd130, 32'd10, 3, 1'b0, 32'hA5A5_0001, 1'b0, last);
        wait_done("up", last);
        run_sweep(32'd100, 32'd125, 32'd10, 1, 1'b0, 32'h0000_0002, 1'b0, last);
        wait_done("clamp", last);
        run_sweep(32'h1000, 32'h0F00, 32'h80, 2, 1'b1, 32'h0000_0003, 1'b0, last);
        wait_done("triangle", last);
        run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0, 1'b1, 32'h0000_0004, 1'b0, last);
        wait_done("top_edge", last);
        run_sweep(32'd5, 32'd50, 32'd0, 2, 1'b1, 32'h0000_0005, 1'b0, last);
        wait_done("zero_step", last);

        // Ready gating before the first dwell and in the middle of one.
        bus.dds_ready = 1'b0;
        run_sweep(32'd200, 32'd240, 32'd10, 6, 1'b0, 32'h0000_0006, 1'b1, last);
        tick(10);
        chk("gated_fcw", 64'(bus.fcw), 64'd200);
        chk("gated_no_events", 64'(exp_q.size()), 64'd5);
        bus.dds_ready = 1'b1;
        ref_cyc = cyc;
        wait_q(4);
        tick(2);
        bus.dds_ready = 1'b0;
        tick(5);
        chk("ready_drop_fcw", 64'(bus.fcw), 64'd210);
        bus.dds_ready = 1'b1;
        ref_cyc = cyc;
        exp_q[0].gap = 7;
        wait_done("ready_gate", last);

        abort_after_first(32'd100, 32'd200, 2);
        abort_after_first(32'd100, 32'd110, 2);

        run_sweep(32'd300, 32'd340, 32'd20, 3, 1'b0, 32'h0BAD_F00D, 1'b0, last);
        tick(4);
        bus.start_fcw    = 32'd7;
        bus.stop_fcw     = 32'd9999;
        bus.step_fcw     = 32'd1;
        bus.dwell        = 16'd9;
        bus.triangle     = 1'b1;
        bus.phase_offset = 32'h55;
        bus.start        = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_done("start_ignored", last);
        chk("start_ignored_offset", 64'(bus.offset), 64'h0BAD_F00D);

        run_sweep(32'd100, 32'd200, 32'd10, 3, 1'b0, 32'h0000_0777, 1'b0, last);
        tick(3);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        chk("midreset_fcw", 64'(bus.fcw), 64'd0);
        chk("midreset_offset", 64'(bus.offset), 64'd0);
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_done", 64'(bus.done), 64'd0);
        chk("midreset_strobe", 64'(bus.step_strobe), 64'd0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 40; i++) begin
            s  = 64'($urandom);
            dd = 64'($urandom_range(0, 3000));
            if ($urandom_range(0, 1) == 1) t = (s + dd > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s + dd;
            else                           t = (s < dd) ? 64'd0 : s - dd;
            dd = (t > s) ? t - s : s - t;
            st = ($urandom_range(0, 7) == 0) ? 32'd0
                 : 32'($urandom_range(32'(dd / 12) + 1, 32'(dd) + 40));
            run_sweep(32'(s), 32'(t), st, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                      $urandom, 1'b0, last);
            wait_done("random", last);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
